// File: rtl/waveform_pkg.sv
// Shared types for the waveform scheduler: FSM state encoding and the
// per-channel set/clear configuration record.
package waveform_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Positions are stored zero-extended to a fixed width so one record type
  // serves any FRAME_LEN up to 2**POS_W cycles.
  localparam int POS_W = 8;

  typedef struct packed {
    logic [POS_W-1:0] set;
    logic [POS_W-1:0] clr;
  } ch_cfg_t;

endpackage

// File: rtl/wave_channel.sv
// One waveform channel: shadow/active configuration pair, commit at frame
// boundaries, and the registered set/clear output rule.
module wave_channel
  import waveform_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [CW-1:0] wr_set,
  input  logic [CW-1:0] wr_clr,
  input  logic          commit,
  input  logic          en,
  input  logic [CW-1:0] cnt,
  output logic          sig
);

  ch_cfg_t          shadow;
  ch_cfg_t          active;
  logic             sig_next;
  logic [POS_W-1:0] cnt_ext;

  // Host writes land in the shadow set only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
    end else if (we) begin
      shadow.set <= POS_W'(wr_set);
      shadow.clr <= POS_W'(wr_clr);
    end
  end

  // Active set follows shadow only when a new frame is loaded, so a write
  // in the commit cycle itself waits for the following frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= '0;
    end else if (commit) begin
      active <= shadow;
    end
  end

  // Clear has priority over set; outside an active frame the output is forced low.
  always_comb begin
    cnt_ext  = POS_W'(cnt);
    sig_next = sig;
    if (!en) begin
      sig_next = 1'b0;
    end else if (cnt_ext == active.clr) begin
      sig_next = 1'b0;
    end else if (cnt_ext == active.set) begin
      sig_next = 1'b1;
    end
  end

  // Output flop gives the fixed one-cycle latency after the matching count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig <= 1'b0;
    end else begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/waveform_scheduler.sv
// Multi-channel waveform scheduler: frame FSM (IDLE/RUN/DRAIN), frame
// position counter, configuration write decode and one channel per output.
module waveform_scheduler
  import waveform_pkg::*;
#(
  parameter int NCH       = 3,
  parameter int FRAME_LEN = 8,
  parameter int CW        = $clog2(FRAME_LEN),
  parameter int IW        = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           stop,
  input  logic           cfg_we,
  input  logic [IW-1:0]  cfg_ch,
  input  logic [CW-1:0]  cfg_set,
  input  logic [CW-1:0]  cfg_clr,
  output logic [NCH-1:0] sig,
  output logic [CW-1:0]  cnt,
  output logic           frame_start,
  output logic           busy
);

  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cnt_next;
  logic          frame_start_next;
  logic          launch;
  logic          wrap;
  logic          commit;
  logic          run_en;

  // Next-state, counter and strobe decode; stop beats start in IDLE.
  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    launch           = (state == IDLE) && start && !stop;
    wrap             = (state != IDLE) && (cnt == LAST);
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (launch) state_next = RUN;
      end
      RUN: begin
        cnt_next = wrap ? '0 : cnt + CW'(1);
        if (stop) state_next = DRAIN;
      end
      DRAIN: begin
        cnt_next = wrap ? '0 : cnt + CW'(1);
        if (wrap) state_next = IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = IDLE;
      end
    endcase
    // Any edge that loads cnt=0 while running commits shadow config; the
    // frame-start pulse is suppressed when that frame will be a drain frame.
    commit           = launch || ((state == RUN) && wrap);
    frame_start_next = launch || ((state == RUN) && wrap && !stop);
    // Channels evaluate only while a frame is in progress and not ending.
    run_en           = (state != IDLE) && (state_next != IDLE);
  end

  // State, counter and frame-start registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      frame_start <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      frame_start <= frame_start_next;
    end
  end

  assign busy = (state != IDLE);

  // One channel per output; indices at or above NCH select nothing.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    wave_channel #(.CW(CW)) u_ch (
      .clk    (clk),
      .rst    (rst),
      .we     (cfg_we && (cfg_ch == IW'(gi))),
      .wr_set (cfg_set),
      .wr_clr (cfg_clr),
      .commit (commit),
      .en     (run_en),
      .cnt    (cnt),
      .sig    (sig[gi])
    );
  end

endmodule
